// File: rtl/uart_tx_fifo_drain.sv
// UART transmitter draining a first-word-fall-through FIFO: start bit, DATA_WIDTH
// data bits LSB first, STOP_BITS stop bits, no parity, back-to-back while data lasts.
module uart_tx_fifo_drain #(
  parameter int DATA_WIDTH = 8,
  parameter int BAUD_DIV   = 868,
  parameter int STOP_BITS  = 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tx_enable,
  input  logic [DATA_WIDTH-1:0] fifo_data,
  input  logic                  fifo_empty,
  input  logic                  fifo_write_active,
  output logic                  fifo_deQ,
  output logic                  tx,
  output logic                  busy
);
  localparam int BW = $clog2(BAUD_DIV);
  localparam int CW = $clog2(DATA_WIDTH + 1);
  localparam logic [BW-1:0] BAUD_LAST = BW'(BAUD_DIV - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] STOP_LAST = CW'(STOP_BITS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t                r_state;
  logic [BW-1:0]         r_baud;
  logic [CW-1:0]         r_bit;
  logic [DATA_WIDTH-1:0] r_shift;
  logic                  r_tx;
  logic                  r_busy;

  logic w_baud_end;
  logic w_last_stop;
  logic w_load;

  assign w_baud_end  = (r_baud == BAUD_LAST);
  assign w_last_stop = (r_state == STOP) && w_baud_end && (r_bit == STOP_LAST);
  // Loading in the last stop cycle lets the next start bit follow with no idle gap.
  assign w_load      = ~reset & tx_enable & ~fifo_empty & ~fifo_write_active &
                       ((r_state == IDLE) | w_last_stop);

  assign fifo_deQ = w_load;
  assign tx       = r_tx;
  assign busy     = r_busy;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= '0;
      r_tx    <= 1'b1;
      r_busy  <= 1'b0;
    end else if (w_load) begin
      r_state <= START;
      r_baud  <= '0;
      r_bit   <= '0;
      r_shift <= fifo_data;
      r_tx    <= 1'b0;
      r_busy  <= 1'b1;
    end else begin
      case (r_state)
        IDLE: ;
        START: begin
          if (w_baud_end) begin
            r_baud  <= '0;
            r_state <= DATA;
            r_tx    <= r_shift[0];
            r_shift <= r_shift >> 1;
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        DATA: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == DATA_LAST) begin
              r_state <= STOP;
              r_bit   <= '0;
              r_tx    <= 1'b1;
            end else begin
              r_bit   <= r_bit + 1'b1;
              r_tx    <= r_shift[0];
              r_shift <= r_shift >> 1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        STOP: begin
          if (w_baud_end) begin
            r_baud <= '0;
            if (r_bit == STOP_LAST) begin
              r_state <= IDLE;
              r_bit   <= '0;
              r_busy  <= 1'b0;
            end else begin
              r_bit <= r_bit + 1'b1;
            end
          end else begin
            r_baud <= r_baud + 1'b1;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo_drain.sv
// Scoreboard bench: bytes are queued as expected when pushed into the FIFO model and
// compared against frames decoded from tx by an independent receiver.
module tb_uart_tx_fifo_drain;
  localparam int DW = 8, BD = 4, SB = 1;
  localparam int FRAME = (1 + DW + SB) * BD;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          tx_enable = 1'b1;
  logic [DW-1:0] fifo_data = '0;
  logic          fifo_empty = 1'b1;
  logic          fifo_write_active = 1'b0;
  logic          fifo_deQ, tx, busy;

  always #5 clock = ~clock;

  uart_tx_fifo_drain #(.DATA_WIDTH(DW), .BAUD_DIV(BD), .STOP_BITS(SB)) dut (
    .clock(clock), .reset(reset), .tx_enable(tx_enable), .fifo_data(fifo_data),
    .fifo_empty(fifo_empty), .fifo_write_active(fifo_write_active),
    .fifo_deQ(fifo_deQ), .tx(tx), .busy(busy)
  );

  logic [DW-1:0] fq[$];
  logic [DW-1:0] sb[$];
  int pop_cyc[$];
  int n_tests = 0, n_fail = 0;
  int cyc = 0, n_pop = 0, n_rx = 0, n_abort = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic refresh();
    fifo_empty = (fq.size() == 0);
    fifo_data  = (fq.size() != 0) ? fq[0] : '0;
  endtask

  task automatic push(input logic [DW-1:0] b);
    fq.push_back(b);
    sb.push_back(b);
    refresh();
  endtask

  // FWFT FIFO: the pop strobe seen at the edge removes the head just after it.
  task automatic fifo_proc();
    logic p;
    forever begin
      @(posedge clock);
      p = fifo_deQ;
      if (p) begin
        n_pop++;
        pop_cyc.push_back(cyc);
      end
      cyc++;
      #1;
      if (p && fq.size() != 0) void'(fq.pop_front());
      refresh();
    end
  endtask

  // Samples mid-bit; a frame whose busy drops early was aborted by reset.
  task automatic rx_proc();
    logic [DW-1:0] d;
    bit ab;
    int b;
    forever begin
      @(negedge clock);
      if (!reset && tx === 1'b0) begin
        ab = 0;
        d  = '0;
        for (int c = 2; c <= FRAME; c++) begin
          @(negedge clock);
          if (!busy) begin
            ab = 1;
            break;
          end
          if (c % BD == BD / 2) begin
            b = c / BD;
            if (b == 0) chk("rx_start_bit", {31'b0, tx}, 0);
            else if (b <= DW) d[b-1] = tx;
            else chk("rx_stop_bit", {31'b0, tx}, 1);
          end
        end
        if (ab) begin
          n_abort++;
          if (sb.size() != 0) void'(sb.pop_front());
        end else begin
          n_rx++;
          if (sb.size() != 0) chk("rx_byte", {24'b0, d}, {24'b0, sb.pop_front()});
          else chk("rx_unexpected_frame", 1, 0);
        end
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 400; i++) begin
      @(negedge clock);
      if (!busy && fq.size() == 0) return;
    end
    chk("idle_timeout", 1, 0);
  endtask

  initial begin
    int p0, pc, run, bad;
    logic [DW-1:0] a5;
    logic exp_tx;
    fork
      fifo_proc();
      rx_proc();
      begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
      end
    join_none

    // Reset state and empty-FIFO idling
    repeat (3) @(negedge clock);
    chk("rst_tx", {31'b0, tx}, 1);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_deq", {31'b0, fifo_deQ}, 0);
    reset = 1'b0;
    bad = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clock);
      if (tx !== 1'b1 || busy !== 1'b0 || fifo_deQ !== 1'b0) bad++;
    end
    chk("t1_idle_quiet", bad, 0);

    // Single frame 0xA5: exact waveform and busy window
    @(negedge clock);
    a5 = 8'hA5;
    push(a5);
    #1 chk("t2_deq", {31'b0, fifo_deQ}, 1);
    p0 = n_pop;
    bad = 0;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clock);
      if (k <= 40) begin
        b_calc: begin
          int bi;
          bi = (k - 1) / BD;
          exp_tx = (bi == 0) ? 1'b0 : (bi <= DW) ? a5[bi-1] : 1'b1;
        end
        if (tx !== exp_tx || busy !== 1'b1 || fifo_deQ !== 1'b0) bad++;
      end else begin
        chk("t2_busy_drop", {31'b0, busy}, 0);
      end
    end
    chk("t2_wave", bad, 0);
    chk("t2_pops", n_pop - p0, 1);

    // Back-to-back frames
    @(negedge clock);
    push(8'h00);
    push(8'hFF);
    push(8'h3C);
    #1 chk("t3_deq", {31'b0, fifo_deQ}, 1);
    pc = pop_cyc.size();
    run = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (busy) begin
        run++;
        if (run == FRAME + 1) chk("t3_start2", {31'b0, tx}, 0);
      end else break;
    end
    chk("t3_busy_run", run, 3 * FRAME);
    chk("t3_pops", pop_cyc.size() - pc, 3);
    if (pop_cyc.size() >= pc + 3) begin
      chk("t3_gap1", pop_cyc[pc+1] - pop_cyc[pc], FRAME);
      chk("t3_gap2", pop_cyc[pc+2] - pop_cyc[pc+1], FRAME);
    end

    // Write strobe masks the load
    @(negedge clock);
    fifo_write_active = 1'b1;
    push(8'h42);
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      if (fifo_deQ !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("t4_masked", bad, 0);
    fifo_write_active = 1'b0;
    #1 chk("t4_deq", {31'b0, fifo_deQ}, 1);
    wait_idle();

    // tx_enable dropped mid-frame
    @(negedge clock);
    push(8'h81);
    push(8'h7E);
    #1 chk("t5_deq", {31'b0, fifo_deQ}, 1);
    p0 = n_pop;
    for (int k = 1; k <= 41; k++) begin
      @(negedge clock);
      if (k == 10) tx_enable = 1'b0;
      if (k == 40) chk("t5_busy_end", {31'b0, busy}, 1);
      if (k == 41) chk("t5_busy_drop", {31'b0, busy}, 0);
    end
    chk("t5_pops", n_pop - p0, 1);
    bad = 0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (fifo_deQ !== 1'b0 || busy !== 1'b0) bad++;
    end
    chk("t5_hold", bad, 0);
    tx_enable = 1'b1;
    #1 chk("t5_reenable_deq", {31'b0, fifo_deQ}, 1);
    wait_idle();

    // Reset mid-frame aborts, next load sends a whole frame
    @(negedge clock);
    push(8'h5A);
    push(8'hC3);
    #1 chk("t6_deq", {31'b0, fifo_deQ}, 1);
    p0 = n_pop;
    repeat (15) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("t6_rst_tx", {31'b0, tx}, 1);
    chk("t6_rst_busy", {31'b0, busy}, 0);
    chk("t6_rst_deq", {31'b0, fifo_deQ}, 0);
    chk("t6_pops", n_pop - p0, 1);
    reset = 1'b0;
    #1 chk("t6_reload_deq", {31'b0, fifo_deQ}, 1);
    wait_idle();

    repeat (5) @(negedge clock);
    chk("end_aborts", n_abort, 1);
    chk("end_frames", n_rx, 8);
    chk("end_sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
